// File: rtl/password_entry_if.sv
// Keypad / comparator bundle for the password entry controller.
interface password_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        lock_in;
  logic [11:0] pass_in;
  logic [11:0] pass_set;
  logic        enb;
  logic [1:0]  digit_cnt;
  logic        set_mode;
  logic        lockout;

  modport master (
    output key_valid, key_code, lock_in,
    input  pass_in, pass_set, enb,
    input  digit_cnt, set_mode, lockout
  );

  modport slave (
    input  key_valid, key_code, lock_in,
    output pass_in, pass_set, enb,
    output digit_cnt, set_mode, lockout
  );
endinterface

// File: rtl/password_entry_ctrl.sv
// Keypad password entry: digit capture, compare strobe,
// password change mode and brute-force lockout.
module password_entry_ctrl #(
  parameter logic [11:0] DEFAULT_PASS   = 12'h123,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 1000
) (
  input logic              clk,
  input logic              rst,
  password_entry_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, CHECK, WAIT, SET, LOCKOUT
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] pass_in_q, pass_in_nxt;
  logic [11:0] new_buf, new_buf_nxt;
  logic [11:0] pass_set_q, pass_set_nxt;
  logic [1:0]  cnt_q, cnt_nxt;
  logic [2:0]  fail_q, fail_nxt, fail_inc;
  logic [15:0] lock_cnt, lock_cnt_nxt;
  logic        enb_q;

  logic is_digit, is_enter, is_clear, is_set;

  assign is_digit = bus.key_code <= 4'd9;
  assign is_enter = bus.key_code == 4'hA;
  assign is_clear = bus.key_code == 4'hB;
  assign is_set   = bus.key_code == 4'hC;
  assign fail_inc = fail_q + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pass_in_q  <= '0;
      new_buf    <= '0;
      pass_set_q <= DEFAULT_PASS;
      cnt_q      <= '0;
      fail_q     <= '0;
      lock_cnt   <= '0;
      enb_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      pass_in_q  <= pass_in_nxt;
      new_buf    <= new_buf_nxt;
      pass_set_q <= pass_set_nxt;
      cnt_q      <= cnt_nxt;
      fail_q     <= fail_nxt;
      lock_cnt   <= lock_cnt_nxt;
      enb_q      <= state_nxt == CHECK;
    end
  end

  always_comb begin
    state_nxt    = state;
    pass_in_nxt  = pass_in_q;
    new_buf_nxt  = new_buf;
    pass_set_nxt = pass_set_q;
    cnt_nxt      = cnt_q;
    fail_nxt     = fail_q;
    lock_cnt_nxt = lock_cnt;
    unique case (state)
      IDLE: if (bus.key_valid) begin
        unique case (1'b1)
          is_digit: if (cnt_q != 2'd3) begin
            pass_in_nxt = {pass_in_q[7:0], bus.key_code};
            cnt_nxt     = cnt_q + 2'd1;
          end
          is_enter: if (cnt_q == 2'd3) begin
            state_nxt = CHECK;
          end else begin
            pass_in_nxt = '0;
            cnt_nxt     = '0;
          end
          is_clear: begin
            pass_in_nxt = '0;
            cnt_nxt     = '0;
          end
          is_set: if (bus.lock_in && cnt_q == 2'd0) begin
            state_nxt   = SET;
            new_buf_nxt = '0;
          end
          default: ;
        endcase
      end
      CHECK: state_nxt = WAIT;
      WAIT: begin
        pass_in_nxt = '0;
        cnt_nxt     = '0;
        if (bus.lock_in) begin
          fail_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          fail_nxt = fail_inc;
          if (fail_inc == 3'(MAX_FAIL)) begin
            state_nxt    = LOCKOUT;
            lock_cnt_nxt = 16'(LOCKOUT_CYCLES - 1);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      SET: if (bus.key_valid) begin
        unique case (1'b1)
          is_digit: if (cnt_q != 2'd3) begin
            new_buf_nxt = {new_buf[7:0], bus.key_code};
            cnt_nxt     = cnt_q + 2'd1;
          end
          is_enter: if (cnt_q == 2'd3) begin
            pass_set_nxt = new_buf;
            new_buf_nxt  = '0;
            cnt_nxt      = '0;
            state_nxt    = IDLE;
          end
          is_clear: begin
            new_buf_nxt = '0;
            cnt_nxt     = '0;
            state_nxt   = IDLE;
          end
          default: ;
        endcase
      end
      LOCKOUT: if (lock_cnt == 16'd0) begin
        fail_nxt  = '0;
        state_nxt = IDLE;
      end else begin
        lock_cnt_nxt = lock_cnt - 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.pass_in   = pass_in_q;
  assign bus.pass_set  = pass_set_q;
  assign bus.enb       = enb_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.set_mode  = state == SET;
  assign bus.lockout   = state == LOCKOUT;

endmodule
